// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back path: widths, FSM states
// and the default destination for the upper half of multiply/divide results.
package regfile_pkg;

    localparam int REG_ADDR_W   = 4;
    localparam int DATA_W       = 16;
    localparam int NUM_REGS     = 16;
    localparam int STARVE_CNT_W = 3;

    typedef enum logic {
        WB_IDLE,
        WB_MD_HI
    } wb_state_e;

    localparam logic [REG_ADDR_W-1:0] DEFAULT_HI_REG = 4'd0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the execute/memory requesters and the arbiter,
// including the register-file write port the arbiter drives.
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0]     mem_data;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0]     alu_data;

    logic                  md_valid;
    logic                  md_ready;
    logic [REG_ADDR_W-1:0] md_reg;
    logic [DATA_W-1:0]     md_lo;
    logic [DATA_W-1:0]     md_hi;

    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0]     wr_data;
    logic                  busy;

    modport master (
        output mem_valid, mem_reg, mem_data,
        output alu_valid, alu_reg, alu_data,
        output md_valid, md_reg, md_lo, md_hi,
        input  mem_ready, alu_ready, md_ready,
        input  wr_en, wr_reg, wr_data, busy
    );

    modport slave (
        input  mem_valid, mem_reg, mem_data,
        input  alu_valid, alu_reg, alu_data,
        input  md_valid, md_reg, md_lo, md_hi,
        output mem_ready, alu_ready, md_ready,
        output wr_en, wr_reg, wr_data, busy
    );

endinterface

// File: rtl/regfile_wb_arbiter_starve_counter.sv
// Saturating counter of consecutive cycles the ALU request has been blocked;
// hit tells the arbiter to hand the write port to the ALU.
module wb_starve_counter
    import regfile_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt;

    assign hit = (cnt == LIM);

    // Neither inc nor clr means hold, which is what the MD_HI cycle relies on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !hit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between load, multiply/divide
// and ALU results; multiply/divide results take two sequenced writes.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int                    STARVE_LIMIT = 4,
    parameter logic [REG_ADDR_W-1:0] HI_REG       = DEFAULT_HI_REG
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  wb
);

    wb_state_e             state;
    logic [DATA_W-1:0]     hi_buf;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0]     wr_data;

    logic idle;
    logic starve_hit;
    logic mem_ready;
    logic md_ready;
    logic alu_ready;
    logic mem_go;
    logic md_go;
    logic alu_go;

    // Priority mem > md > alu, except a starved ALU takes the port outright.
    assign idle      = (state == WB_IDLE);
    assign mem_ready = idle & ~starve_hit;
    assign md_ready  = idle & ~starve_hit & ~wb.mem_valid;
    assign alu_ready = idle & (starve_hit | (~wb.mem_valid & ~wb.md_valid));

    assign mem_go = wb.mem_valid & mem_ready;
    assign md_go  = wb.md_valid  & md_ready;
    assign alu_go = wb.alu_valid & alu_ready;

    assign wb.mem_ready = mem_ready;
    assign wb.md_ready  = md_ready;
    assign wb.alu_ready = alu_ready;
    assign wb.wr_en     = wr_en;
    assign wb.wr_reg    = wr_reg;
    assign wb.wr_data   = wr_data;
    assign wb.busy      = (state == WB_MD_HI);

    wb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (idle & wb.alu_valid & ~alu_ready),
        .clr (idle & (~wb.alu_valid | alu_go)),
        .hit (starve_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= WB_IDLE;
            hi_buf  <= '0;
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (mem_go) begin
                        wr_en   <= 1'b1;
                        wr_reg  <= wb.mem_reg;
                        wr_data <= wb.mem_data;
                    end else if (md_go) begin
                        wr_en   <= 1'b1;
                        wr_reg  <= wb.md_reg;
                        wr_data <= wb.md_lo;
                        hi_buf  <= wb.md_hi;
                        state   <= WB_MD_HI;
                    end else if (alu_go) begin
                        wr_en   <= 1'b1;
                        wr_reg  <= wb.alu_reg;
                        wr_data <= wb.alu_data;
                    end else begin
                        wr_en   <= 1'b0;
                    end
                end
                WB_MD_HI: begin
                    wr_en   <= 1'b1;
                    wr_reg  <= HI_REG;
                    wr_data <= hi_buf;
                    state   <= WB_IDLE;
                end
                default: begin
                    wr_en <= 1'b0;
                    state <= WB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus a randomized run checked cycle by cycle against a
// behavioural model of the write-back arbitration rules.
module tb_regfile_wb_arbiter;

    localparam int         STARVE_LIMIT = 4;
    localparam logic [3:0] HI_REG       = 4'd0;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [15:0] rf [16];

    regfile_wb_arbiter_if wb ();

    regfile_wb_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .HI_REG       (HI_REG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in register file: captures whatever the arbiter writes.
    always @(posedge clk) begin
        if (wb.wr_en) rf[wb.wr_reg] <= wb.wr_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wb.mem_valid = 0; wb.mem_reg = 0; wb.mem_data = 0;
        wb.alu_valid = 0; wb.alu_reg = 0; wb.alu_data = 0;
        wb.md_valid  = 0; wb.md_reg  = 0; wb.md_lo    = 0; wb.md_hi = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        #12;
        tests_run++;
        if ({wb.wr_en, wb.wr_reg, wb.wr_data, wb.busy} !== 22'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got en=%b reg=%0d data=%h busy=%b, want all 0",
                     wb.wr_en, wb.wr_reg, wb.wr_data, wb.busy);
        end
        tests_run++;
        if ({wb.mem_ready, wb.md_ready, wb.alu_ready} !== 3'b111) begin
            tests_failed++;
            $display("[TB] FAIL reset_readies: got mem/md/alu=%b%b%b, want 111",
                     wb.mem_ready, wb.md_ready, wb.alu_ready);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu_single();
        wb.alu_valid = 1; wb.alu_reg = 4'd3; wb.alu_data = 16'h1234;
        #1;
        tests_run++;
        if (wb.alu_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL alu_ready: got %b, want 1", wb.alu_ready);
        end
        tick();
        wb.alu_valid = 0;
        tests_run++;
        if ({wb.wr_en, wb.wr_reg, wb.wr_data} !== {1'b1, 4'd3, 16'h1234}) begin
            tests_failed++;
            $display("[TB] FAIL alu_write: got en=%b reg=%0d data=%h, want 1/3/1234",
                     wb.wr_en, wb.wr_reg, wb.wr_data);
        end
        tick();
        tests_run++;
        if ({wb.wr_en, wb.wr_reg} !== {1'b0, 4'd3}) begin
            tests_failed++;
            $display("[TB] FAIL alu_idle: got en=%b reg=%0d, want 0/3 (held)", wb.wr_en, wb.wr_reg);
        end
    endtask

    task automatic test_mem_alu_priority();
        wb.mem_valid = 1; wb.mem_reg = 4'd5; wb.mem_data = 16'hAAAA;
        wb.alu_valid = 1; wb.alu_reg = 4'd6; wb.alu_data = 16'h5555;
        #1;
        tests_run++;
        if ({wb.mem_ready, wb.alu_ready} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL prio_readies: got mem/alu=%b%b, want 10", wb.mem_ready, wb.alu_ready);
        end
        tick();
        wb.mem_valid = 0;
        tests_run++;
        if ({wb.wr_en, wb.wr_reg, wb.wr_data} !== {1'b1, 4'd5, 16'hAAAA}) begin
            tests_failed++;
            $display("[TB] FAIL prio_first: got en=%b reg=%0d data=%h, want 1/5/aaaa",
                     wb.wr_en, wb.wr_reg, wb.wr_data);
        end
        tick();
        wb.alu_valid = 0;
        tests_run++;
        if ({wb.wr_en, wb.wr_reg, wb.wr_data} !== {1'b1, 4'd6, 16'h5555}) begin
            tests_failed++;
            $display("[TB] FAIL prio_second: got en=%b reg=%0d data=%h, want 1/6/5555",
                     wb.wr_en, wb.wr_reg, wb.wr_data);
        end
        tick();
    endtask

    task automatic test_md_pair();
        wb.md_valid = 1; wb.md_reg = 4'd7; wb.md_lo = 16'h0F0F; wb.md_hi = 16'hF0F0;
        #1;
        tests_run++;
        if (wb.md_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL md_ready: got %b, want 1", wb.md_ready);
        end
        tick();
        wb.md_valid = 0;
        tests_run++;
        if ({wb.wr_en, wb.wr_reg, wb.wr_data, wb.busy} !== {1'b1, 4'd7, 16'h0F0F, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL md_low: got en=%b reg=%0d data=%h busy=%b, want 1/7/0f0f/1",
                     wb.wr_en, wb.wr_reg, wb.wr_data, wb.busy);
        end
        tests_run++;
        if ({wb.mem_ready, wb.md_ready, wb.alu_ready} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL md_hi_readies: got mem/md/alu=%b%b%b, want 000",
                     wb.mem_ready, wb.md_ready, wb.alu_ready);
        end
        tick();
        tests_run++;
        if ({wb.wr_en, wb.wr_reg, wb.wr_data, wb.busy} !== {1'b1, HI_REG, 16'hF0F0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL md_high: got en=%b reg=%0d data=%h busy=%b, want 1/%0d/f0f0/0",
                     wb.wr_en, wb.wr_reg, wb.wr_data, wb.busy, HI_REG);
        end
        tick();
    endtask

    task automatic test_starvation();
        wb.mem_valid = 1; wb.mem_reg = 4'd1; wb.mem_data = 16'h1111;
        wb.alu_valid = 1; wb.alu_reg = 4'd2; wb.alu_data = 16'h2222;
        for (int i = 1; i <= STARVE_LIMIT; i++) begin
            #1;
            tests_run++;
            if ({wb.mem_ready, wb.alu_ready} !== 2'b10) begin
                tests_failed++;
                $display("[TB] FAIL starve_wait cycle %0d: got mem/alu=%b%b, want 10",
                         i, wb.mem_ready, wb.alu_ready);
            end
            tick();
            tests_run++;
            if ({wb.wr_en, wb.wr_reg, wb.wr_data} !== {1'b1, 4'd1, 16'h1111}) begin
                tests_failed++;
                $display("[TB] FAIL starve_mem_write cycle %0d: got en=%b reg=%0d data=%h, want 1/1/1111",
                         i, wb.wr_en, wb.wr_reg, wb.wr_data);
            end
        end
        #1;
        tests_run++;
        if ({wb.mem_ready, wb.alu_ready} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL starve_override: got mem/alu=%b%b, want 01", wb.mem_ready, wb.alu_ready);
        end
        tick();
        wb.alu_valid = 0;
        tests_run++;
        if ({wb.wr_en, wb.wr_reg, wb.wr_data} !== {1'b1, 4'd2, 16'h2222}) begin
            tests_failed++;
            $display("[TB] FAIL starve_alu_write: got en=%b reg=%0d data=%h, want 1/2/2222",
                     wb.wr_en, wb.wr_reg, wb.wr_data);
        end
        #1;
        tests_run++;
        if (wb.mem_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL starve_mem_resume: got mem_ready=%b, want 1", wb.mem_ready);
        end
        tick();
        wb.mem_valid = 0;
        tests_run++;
        if ({wb.wr_en, wb.wr_reg} !== {1'b1, 4'd1}) begin
            tests_failed++;
            $display("[TB] FAIL starve_mem_after: got en=%b reg=%0d, want 1/1", wb.wr_en, wb.wr_reg);
        end
        tick();
    endtask

    task automatic test_reset_mid_md();
        wb.md_valid = 1; wb.md_reg = 4'd9; wb.md_lo = 16'h1357; wb.md_hi = 16'h2468;
        tick();
        wb.md_valid = 0;
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({wb.wr_en, wb.wr_reg, wb.wr_data, wb.busy} !== 22'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_md: got en=%b reg=%0d data=%h busy=%b, want all 0",
                     wb.wr_en, wb.wr_reg, wb.wr_data, wb.busy);
        end
        #2;
        rst = 1'b1;
        tick();
        tests_run++;
        if ({wb.wr_en, wb.wr_data, wb.busy} !== 18'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_drops_hi: got en=%b data=%h busy=%b, want 0/0000/0",
                     wb.wr_en, wb.wr_data, wb.busy);
        end
    endtask

    task automatic test_md_same_reg();
        wb.md_valid = 1; wb.md_reg = HI_REG; wb.md_lo = 16'hAAAA; wb.md_hi = 16'hBBBB;
        tick();
        wb.md_valid = 0;
        tests_run++;
        if ({wb.wr_en, wb.wr_reg, wb.wr_data} !== {1'b1, HI_REG, 16'hAAAA}) begin
            tests_failed++;
            $display("[TB] FAIL same_reg_low: got en=%b reg=%0d data=%h, want 1/%0d/aaaa",
                     wb.wr_en, wb.wr_reg, wb.wr_data, HI_REG);
        end
        tick();
        tests_run++;
        if ({wb.wr_en, wb.wr_reg, wb.wr_data} !== {1'b1, HI_REG, 16'hBBBB}) begin
            tests_failed++;
            $display("[TB] FAIL same_reg_high: got en=%b reg=%0d data=%h, want 1/%0d/bbbb",
                     wb.wr_en, wb.wr_reg, wb.wr_data, HI_REG);
        end
        tick();
        tests_run++;
        if (rf[HI_REG] !== 16'hBBBB) begin
            tests_failed++;
            $display("[TB] FAIL same_reg_final: got reg value %h, want bbbb", rf[HI_REG]);
        end
    endtask

    // Model view: each requester waits with a request until granted; the port
    // goes to mem, then md, then alu, unless alu has waited STARVE_LIMIT cycles.
    task automatic test_random();
        bit          pend_mem, pend_md, pend_alu;
        bit          acc_mem, acc_md, acc_alu;
        bit          m_busy;
        int          m_wait;
        logic [15:0] m_hi;
        bit          exp_en, exp_busy;
        logic [3:0]  exp_reg;
        logic [15:0] exp_data;
        bit          r_mem, r_md, r_alu;

        clear_inputs();
        #1;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        {pend_mem, pend_md, pend_alu, acc_mem, acc_md, acc_alu} = '0;
        m_busy = 0; m_wait = 0; m_hi = 0;
        exp_en = 0; exp_busy = 0; exp_reg = 0; exp_data = 0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            tests_run++;
            if ({wb.wr_en, wb.wr_reg, wb.wr_data, wb.busy} !== {exp_en, exp_reg, exp_data, exp_busy}) begin
                tests_failed++;
                $display("[TB] FAIL rand_out cycle %0d: got en=%b reg=%0d data=%h busy=%b, want en=%b reg=%0d data=%h busy=%b",
                         cyc, wb.wr_en, wb.wr_reg, wb.wr_data, wb.busy, exp_en, exp_reg, exp_data, exp_busy);
            end

            if (acc_mem) pend_mem = 0;
            if (acc_md)  pend_md  = 0;
            if (acc_alu) pend_alu = 0;
            if (!pend_mem && $urandom_range(0, 99) < 70) begin
                pend_mem = 1; wb.mem_reg = 4'($urandom); wb.mem_data = 16'($urandom);
            end
            if (!pend_md && $urandom_range(0, 99) < 25) begin
                pend_md = 1; wb.md_reg = 4'($urandom); wb.md_lo = 16'($urandom); wb.md_hi = 16'($urandom);
            end
            if (!pend_alu && $urandom_range(0, 99) < 50) begin
                pend_alu = 1; wb.alu_reg = 4'($urandom); wb.alu_data = 16'($urandom);
            end
            wb.mem_valid = pend_mem;
            wb.md_valid  = pend_md;
            wb.alu_valid = pend_alu;
            #1;

            if (m_busy) begin
                {r_mem, r_md, r_alu} = 3'b000;
            end else if (m_wait >= STARVE_LIMIT) begin
                {r_mem, r_md, r_alu} = 3'b001;
            end else begin
                r_mem = 1;
                r_md  = !pend_mem;
                r_alu = !pend_mem && !pend_md;
            end
            tests_run++;
            if ({wb.mem_ready, wb.md_ready, wb.alu_ready} !== {r_mem, r_md, r_alu}) begin
                tests_failed++;
                $display("[TB] FAIL rand_ready cycle %0d: got mem/md/alu=%b%b%b, want %b%b%b",
                         cyc, wb.mem_ready, wb.md_ready, wb.alu_ready, r_mem, r_md, r_alu);
            end

            acc_mem = pend_mem && r_mem;
            acc_md  = pend_md  && r_md;
            acc_alu = pend_alu && r_alu;
            if (!m_busy) begin
                if (pend_alu && !acc_alu) m_wait = (m_wait < STARVE_LIMIT) ? m_wait + 1 : STARVE_LIMIT;
                else                      m_wait = 0;
            end
            exp_busy = 0;
            if (m_busy) begin
                exp_en = 1; exp_reg = HI_REG; exp_data = m_hi; m_busy = 0;
            end else if (acc_mem) begin
                exp_en = 1; exp_reg = wb.mem_reg; exp_data = wb.mem_data;
            end else if (acc_md) begin
                exp_en = 1; exp_reg = wb.md_reg; exp_data = wb.md_lo;
                m_hi = wb.md_hi; m_busy = 1; exp_busy = 1;
            end else if (acc_alu) begin
                exp_en = 1; exp_reg = wb.alu_reg; exp_data = wb.alu_data;
            end else begin
                exp_en = 0;
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_alu_single();
        test_mem_alu_priority();
        test_md_pair();
        test_starvation();
        test_reset_mid_md();
        test_md_same_reg();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
